mole_spawner: RTL and testbench
===============================

Name: mole_spawner

Overview:
Game-side initiator for the mole timeout timer. It runs the spawn/visible/gap sequence:
- picks a hole with an LFSR and lights it;
- issues the one-cycle start pulse that arms the timer;
- resolves each mole as hit (correct button) or miss (timeout or wrong button);
- keeps score and miss count, and ends the game at MISS_LIMIT.

It sits between the debounced button block, the timer, and the LED/score display.

Parameters:
NUM_HOLES, 8, number of holes/buttons; legal 2..16
GAP_TICKS, 3, clk_game cycles with no mole between resolve and next spawn; legal >=1
MISS_LIMIT, 3, misses that end the game; legal 1..15
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk_game  in  1  game clock (slow tick domain)
rst_n  in  1  asynchronous active-low reset
enable  in  1  game running; low returns the block to IDLE
btn_pulse  in  NUM_HOLES  one-cycle debounced press per hole
timeout_pulse  in  1  one-cycle timeout from the timer
start  out  1  one-cycle pulse that resets/arms the timer
mole_onehot  out  NUM_HOLES  lit hole, registered; zero when no mole
hit_pulse  out  1  one cycle per hit
miss_pulse  out  1  one cycle per miss
score  out  8  hits, saturating at 255
misses  out  4  misses, saturating at 15
game_over  out  1  high while in OVER

Behaviour:
- Reset (async): state=IDLE, lfsr=LFSR_SEED, and all of these are 0: gap_cnt, hole, start, mole_onehot, hit_pulse, miss_pulse, score, misses, game_over.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every clk_game cycle in every state.
- States: IDLE, GAP, SPAWN, WAIT, OVER.
- IDLE:
  - Outputs quiet; score and misses hold, so the last game stays displayed.
  - enable=1 -> GAP with gap_cnt=0; score and misses clear on that edge.
- GAP:
  - mole_onehot=0; gap_cnt increments each cycle.
  - When gap_cnt==GAP_TICKS-1 -> SPAWN.
- SPAWN (exactly one cycle):
  - start=1, decoded from state.
  - idx = lfsr[3:0] % NUM_HOLES. If idx==hole (the previous hole), use (idx+1)%NUM_HOLES instead, so no hole repeats back to back.
  - Chosen index is latched into hole and mole_onehot on the exit edge -> WAIT.
- WAIT: one branch per cycle, evaluated in this priority order:
  1. btn_pulse[hole]=1 -> hit_pulse=1, score+1 -> GAP.
  2. Else any other btn_pulse bit=1, or timeout_pulse=1 -> miss_pulse=1, misses+1. Multiple wrong bits in one cycle count as one miss. If the new miss count reaches MISS_LIMIT -> OVER, else -> GAP.
  3. Else stay in WAIT.
- Resolve cycle rules:
  - mole_onehot clears on the same edge as the resolve.
  - Hit and timeout in the same cycle: the hit wins; no miss is counted.
- Foreign timeouts: timeout_pulse outside WAIT is ignored. A timer left active after a hit may expire during GAP; that pulse has no effect.
- OVER: game_over=1, mole_onehot=0, no start pulses. Leaves only via enable=0 -> IDLE.
- enable=0 in any state: synchronous -> IDLE on the next edge. mole_onehot, start, hit_pulse, miss_pulse and game_over all clear.
- Pulse outputs (hit_pulse, miss_pulse) are registered and high for exactly one cycle per event.
- Latency: a button press sampled at edge N shows hit_pulse and the score update after edge N.
- Arithmetic: score saturates at 255 and misses at 15; neither wraps.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/GAP/SPAWN/WAIT/OVER, 3-bit);
  - LFSR tap mask;
  - default LFSR_SEED.
- One sub-module, mole_lfsr16 (free-running, seedable), is natural. It is reused wherever the design needs random positions.
- FSM, counters and hole selection stay in mole_spawner.

Test Plan:
- Spawn timing: reset, then enable=1 at edge E with GAP_TICKS=3 -> start high only in the cycle after edge E+3; mole_onehot has one bit set after E+4; no second start pulse appears.
- Hit: in WAIT with hole=5, pulse btn_pulse=8'h20 -> hit_pulse for 1 cycle, score 0->1, mole_onehot=0; next start follows GAP_TICKS+1 cycles later.
- Timeout miss and game over: with the timer at limit 4, leave every mole unpressed -> miss_pulse once per mole, misses 1,2,3; game_over=1 after the 3rd miss and start stays 0 thereafter.
- Contention: btn_pulse[hole] and timeout_pulse in the same cycle -> hit only, score+1, misses unchanged. A wrong button (8'h01 while hole=3) -> miss. timeout_pulse injected during GAP -> no effect.
- Hole selection: compare every spawned hole against a model using the same LFSR and seed -> exact match, never equal to the previous hole, always < NUM_HOLES.
- Enable/reset mid-operation:
  - enable=0 in WAIT -> IDLE next edge, mole_onehot=0, score held.
  - enable=1 again -> score and misses clear.
  - rst_n low mid-WAIT -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/mole_spawner_pkg.sv
// Shared definitions for the mole spawner slice.
// Contents:
//   state_t            : spawner FSM states (3-bit encoding)
//   LFSR_TAP_MASK      : feedback taps of x^16+x^14+x^13+x^11+1
//   DEFAULT_LFSR_SEED  : default non-zero LFSR reset value
//   HOLE_W             : width of a hole index (covers up to 16 holes)
//   lfsr_step()        : one Fibonacci LFSR shift
//   pick_hole()        : random hole index that never repeats the previous one
package mole_spawner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_SPAWN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Right-shifting Fibonacci form: feedback enters at bit 15 and is the
    // XOR of bits 0, 2, 3 and 5 (the reversed tap set of the polynomial).
    localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
    localparam int unsigned HOLE_W            = 4;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

    // Reduce a 4-bit random value onto the hole range; if it lands on the
    // previously lit hole, step to the next hole so moles never repeat.
    function automatic logic [HOLE_W-1:0] pick_hole(
        input logic [3:0]        rnd,
        input logic [HOLE_W-1:0] prev,
        input int unsigned       n
    );
        int unsigned idx;
        idx = {28'd0, rnd} % n;
        if (idx == {28'd0, prev}) begin
            idx = (idx + 1) % n;
        end
        return HOLE_W'(idx);
    endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running, seedable 16-bit Fibonacci LFSR.
// Ports:
//   clk     : clock; the register shifts on every rising edge
//   rst_n   : asynchronous active-low reset, loads SEED
//   o_rand  : low OUT_W bits of the LFSR state
module mole_lfsr16
    import mole_spawner_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_LFSR_SEED,
    parameter int unsigned OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] o_rand
);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_rand = r_state[OUT_W-1:0];

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole game sequencer: spawn / visible / gap loop with scoring.
// Ports:
//   clk_game      : game clock
//   rst_n         : asynchronous active-low reset
//   enable        : game running; low returns to IDLE on the next edge
//   btn_pulse     : one-cycle debounced press per hole
//   timeout_pulse : one-cycle expiry from the mole timer
//   start         : one-cycle pulse arming the mole timer (SPAWN state)
//   mole_onehot   : registered lit hole, zero when no mole is up
//   hit_pulse     : one cycle per hit
//   miss_pulse    : one cycle per miss (timeout or wrong button)
//   score         : hit count, saturates at 255
//   misses        : miss count, saturates at 15
//   game_over     : high while in OVER
module mole_spawner
    import mole_spawner_pkg::*;
#(
    parameter int unsigned NUM_HOLES  = 8,
    parameter int unsigned GAP_TICKS  = 3,
    parameter int unsigned MISS_LIMIT = 3,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_LFSR_SEED
) (
    input  logic                 clk_game,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_HOLES-1:0] btn_pulse,
    input  logic                 timeout_pulse,
    output logic                 start,
    output logic [NUM_HOLES-1:0] mole_onehot,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [7:0]           score,
    output logic [3:0]           misses,
    output logic                 game_over
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_gap_cnt;
    logic [HOLE_W-1:0]     r_hole;
    logic [NUM_HOLES-1:0]  r_mole;
    logic                  r_hit;
    logic                  r_miss;
    logic [7:0]            r_score;
    logic [3:0]            r_misses;

    logic [3:0]            w_rand;
    logic [HOLE_W-1:0]     w_pick;
    logic [NUM_HOLES-1:0]  w_pick_oh;
    logic                  w_hit;
    logic                  w_wrong;
    logic                  w_miss;
    logic                  w_gap_done;
    logic                  w_limit;
    logic [7:0]            w_score_inc;
    logic [3:0]            w_misses_inc;

    mole_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (4)
    ) u_lfsr (
        .clk    (clk_game),
        .rst_n  (rst_n),
        .o_rand (w_rand)
    );

    assign w_pick    = pick_hole(w_rand, r_hole, NUM_HOLES);
    assign w_pick_oh = NUM_HOLES'(1) << w_pick;

    // r_mole is the one-hot of r_hole throughout WAIT, so it doubles as the
    // mask for the correct button. A correct press always beats a wrong
    // press or a timeout in the same cycle.
    assign w_hit   = |(btn_pulse & r_mole);
    assign w_wrong = |(btn_pulse & ~r_mole);
    assign w_miss  = !w_hit && (w_wrong || timeout_pulse);

    assign w_gap_done   = (r_gap_cnt == 16'(GAP_TICKS - 1));
    assign w_score_inc  = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    assign w_misses_inc = (r_misses == 4'hF) ? r_misses : r_misses + 4'd1;
    assign w_limit      = (w_misses_inc >= 4'(MISS_LIMIT));

    // State register
    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_GAP;
                ST_GAP:   if (w_gap_done) w_state_nxt = ST_SPAWN;
                ST_SPAWN: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (w_hit) begin
                        w_state_nxt = ST_GAP;
                    end else if (w_miss) begin
                        w_state_nxt = w_limit ? ST_OVER : ST_GAP;
                    end
                end
                ST_OVER:  w_state_nxt = ST_OVER;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        start     = (r_state == ST_SPAWN);
        game_over = (r_state == ST_OVER);
    end

    // Counters, hole latch and registered pulses
    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
            r_hole    <= '0;
            r_mole    <= '0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_score   <= '0;
            r_misses  <= '0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            if (!enable) begin
                r_mole    <= '0;
                r_gap_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_gap_cnt <= '0;
                        r_score   <= '0;
                        r_misses  <= '0;
                    end
                    ST_GAP: begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                    ST_SPAWN: begin
                        r_hole <= w_pick;
                        r_mole <= w_pick_oh;
                    end
                    ST_WAIT: begin
                        if (w_hit) begin
                            r_hit     <= 1'b1;
                            r_score   <= w_score_inc;
                            r_mole    <= '0;
                            r_gap_cnt <= '0;
                        end else if (w_miss) begin
                            r_miss    <= 1'b1;
                            r_misses  <= w_misses_inc;
                            r_mole    <= '0;
                            r_gap_cnt <= '0;
                        end
                    end
                    default: begin
                        r_mole <= '0;
                    end
                endcase
            end
        end
    end

    assign mole_onehot = r_mole;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign score       = r_score;
    assign misses      = r_misses;

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized self-checking bench for mole_spawner against a behavioural
// game model (phase + countdown, integer LFSR arithmetic).
module tb_mole_spawner;

    localparam int unsigned N    = 8;
    localparam int unsigned GAP  = 3;
    localparam int unsigned LIM  = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int P_IDLE  = 0;
    localparam int P_GAP   = 1;
    localparam int P_SPAWN = 2;
    localparam int P_WAIT  = 3;
    localparam int P_OVER  = 4;

    logic       clk_game = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] btn_pulse = '0;
    logic       timeout_pulse = 1'b0;
    logic       start;
    logic [7:0] mole_onehot;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int          m_phase;
    int          m_gap_left;
    int unsigned m_lfsr;
    int unsigned m_hole;
    int unsigned m_score;
    int unsigned m_misses;
    logic [7:0]  m_mole;
    bit          m_hit;
    bit          m_miss;

    logic [7:0]  last_lit;
    logic [7:0]  prev_mole;

    mole_spawner #(
        .NUM_HOLES  (N),
        .GAP_TICKS  (GAP),
        .MISS_LIMIT (LIM),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk_game      (clk_game),
        .rst_n         (rst_n),
        .enable        (enable),
        .btn_pulse     (btn_pulse),
        .timeout_pulse (timeout_pulse),
        .start         (start),
        .mole_onehot   (mole_onehot),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .score         (score),
        .misses        (misses),
        .game_over     (game_over)
    );

    always #5 clk_game = ~clk_game;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = P_IDLE;
        m_gap_left = 0;
        m_lfsr     = 32'(SEED);
        m_hole     = 0;
        m_score    = 0;
        m_misses   = 0;
        m_mole     = '0;
        m_hit      = 0;
        m_miss     = 0;
        last_lit   = 8'h01;
        prev_mole  = '0;
    endtask

    task automatic model_step(input bit en, input logic [7:0] btn, input bit to);
        int unsigned idx;
        int unsigned fb;
        m_hit  = 0;
        m_miss = 0;
        if (!en) begin
            m_phase = P_IDLE;
            m_mole  = '0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    m_phase    = P_GAP;
                    m_gap_left = GAP;
                    m_score    = 0;
                    m_misses   = 0;
                end
                P_GAP: begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_phase = P_SPAWN;
                end
                P_SPAWN: begin
                    idx = (m_lfsr & 15) % N;
                    if (idx == m_hole) idx = (idx + 1) % N;
                    m_hole  = idx;
                    m_mole  = 8'(1 << idx);
                    m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (((btn >> m_hole) & 8'd1) != 0) begin
                        m_hit      = 1;
                        m_score    = (m_score < 255) ? m_score + 1 : 255;
                        m_mole     = '0;
                        m_phase    = P_GAP;
                        m_gap_left = GAP;
                    end else if (btn != 0 || to) begin
                        m_miss     = 1;
                        m_misses   = (m_misses < 15) ? m_misses + 1 : 15;
                        m_mole     = '0;
                        m_phase    = (m_misses >= LIM) ? P_OVER : P_GAP;
                        m_gap_left = GAP;
                    end
                end
                default: ;
            endcase
        end
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
    endtask

    task automatic check_outputs();
        chk("start",  start,       m_phase == P_SPAWN);
        chk("mole",   mole_onehot, m_mole);
        chk("hit",    hit_pulse,   m_hit);
        chk("miss",   miss_pulse,  m_miss);
        chk("score",  score,       m_score);
        chk("misses", misses,      m_misses);
        chk("over",   game_over,   m_phase == P_OVER);
        chk("onehot", $countones(mole_onehot) <= 1, 1);
        if (prev_mole == 0 && mole_onehot != 0) begin
            chk("norepeat", mole_onehot == last_lit, 0);
            last_lit = mole_onehot;
        end
        prev_mole = mole_onehot;
    endtask

    // Called just after a falling edge: drive, step model, clock, check.
    task automatic cycle(input bit en, input logic [7:0] btn, input bit to);
        enable        = en;
        btn_pulse     = btn;
        timeout_pulse = to;
        model_step(en, btn, to);
        @(posedge clk_game);
        @(negedge clk_game);
        btn_pulse     = '0;
        timeout_pulse = 1'b0;
        check_outputs();
    endtask

    task automatic random_cycle();
        bit          en;
        bit          to;
        logic [7:0]  btn;
        logic [7:0]  hb;
        int unsigned r;
        en  = ($urandom_range(0, 99) != 0);
        if (m_phase == P_OVER) en = ($urandom_range(0, 3) != 0);
        btn = '0;
        to  = 1'b0;
        r   = $urandom_range(0, 9);
        hb  = 8'(1 << m_hole);
        if (m_phase == P_WAIT) begin
            if (r < 3) begin
                btn = hb;
                to  = (r == 0);
            end else if (r == 3) begin
                btn = 8'($urandom_range(1, 255)) & ~hb;
                if (btn == 0) btn = {hb[6:0], hb[7]};
            end else if (r == 4) begin
                to = 1'b1;
            end
        end else begin
            if (r == 0) to = 1'b1;
            if (r == 1) btn = 8'($urandom_range(1, 255));
        end
        cycle(en, btn, to);
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (3) @(negedge clk_game);
        rst_n = 1'b1;
        check_outputs();

        // random play
        for (int i = 0; i < 6000; i++) begin
            random_cycle();
        end

        // asynchronous reset while a mole is lit
        cycle(1'b0, '0, 1'b0);
        guard = 0;
        while (m_phase != P_WAIT && guard < 40) begin
            cycle(1'b1, '0, 1'b0);
            guard++;
        end
        chk("reach_wait", m_phase == P_WAIT && mole_onehot != 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mole",  mole_onehot, 0);
        chk("arst_start", start,       0);
        chk("arst_hit",   hit_pulse,   0);
        chk("arst_miss",  miss_pulse,  0);
        chk("arst_score", score,       0);
        chk("arst_miss_cnt", misses,   0);
        chk("arst_over",  game_over,   0);
        model_reset();
        @(negedge clk_game);
        rst_n = 1'b1;
        check_outputs();

        // perfect player: score must saturate at 255
        for (int i = 0; i < 1500; i++) begin
            if (m_phase == P_WAIT) cycle(1'b1, 8'(1 << m_hole), 1'b0);
            else                   cycle(1'b1, '0, 1'b0);
        end
        chk("score_sat", score, 255);

        // mole left alone: timeouts end the game after three misses
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, '0, m_phase == P_WAIT);
        end
        chk("over_end", game_over, 1);
        chk("misses_end", misses, LIM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
